// File: rtl/mem_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter_if
//
// Bundles the signals between the arbiter and the rest of the system:
//   - instruction-fetch requester  (inst_req/inst_addr -> inst_ack/inst_rdata)
//   - load/store requester         (data_req/data_we/data_addr/data_wdata/
//                                   data_wstrb -> data_ack/data_rdata)
//   - single-beat AXI master channels AR, R, AW, W, B
//
// Modports:
//   master : the arbiter's view. It drives the requester acks and read data,
//            and drives the AXI master-side VALID/READY/address/data signals.
//   slave  : the environment's view. It drives the requests and the AXI
//            slave responses.
// ---------------------------------------------------------------------------
interface mem_access_arbiter_if;
    // Instruction-fetch requester
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;

    // Load/store requester
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_ack;
    logic [31:0] data_rdata;

    // AXI read address / read data
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    // AXI write address / write data / write response
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_req, inst_addr,
        output inst_ack, inst_rdata,
        input  data_req, data_we, data_addr, data_wdata, data_wstrb,
        output data_ack, data_rdata,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_ack, inst_rdata,
        output data_req, data_we, data_addr, data_wdata, data_wstrb,
        input  data_ack, data_rdata,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter
//
// Shares one single-beat AXI master port between an instruction-fetch
// requester and a load/store requester. Exactly one AXI transaction is in
// flight at a time. When both requesters ask in the same IDLE cycle, the one
// not granted last wins (round-robin); after reset the last grant is "inst",
// so data wins the first tie.
//
// Ports:
//   CCLK  in   core clock, all logic rising-edge
//   CRST  in   synchronous active-high reset; abandons any transaction
//   bus   ---  mem_access_arbiter_if.master (requester + AXI channels)
//   busy  out  high whenever the controller is not IDLE
//   err   out  sticky flag, set by any non-OKAY RRESP/BRESP, cleared by CRST
//
// Flow:  IDLE -> AR -> R -> DONE -> IDLE          (fetch or load)
//        IDLE -> AW_W -> B -> DONE -> IDLE        (store)
// Every AXI VALID/READY and every ACK is decoded from the state register and
// the per-channel "done" flags, never from requester inputs.
// ---------------------------------------------------------------------------
module mem_access_arbiter (
    input  logic                        CCLK,
    input  logic                        CRST,
    mem_access_arbiter_if.master        bus,
    output logic                        busy,
    output logic                        err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    // Transaction context captured on grant
    logic        owner_data_reg;   // 1: data requester owns the transaction
    logic        last_data_reg;    // 1: last grant went to data, 0: to inst
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;

    // AW and W complete independently; these remember which one finished
    logic        aw_done_reg;
    logic        w_done_reg;

    logic [31:0] rdata_reg;
    logic        err_reg;

    // Grant decision (only meaningful in IDLE)
    logic        req_any;
    logic        grant_data;
    logic        grant_store;

    // Handshake decodes
    logic        ar_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_ok;
    logic        w_ok;

    // -----------------------------------------------------------------------
    // Grant and handshake decodes
    // -----------------------------------------------------------------------
    assign req_any     = bus.inst_req | bus.data_req;
    // Data wins when it is the only requester, or on a tie when inst was
    // granted last.
    assign grant_data  = bus.data_req & (~bus.inst_req | ~last_data_reg);
    assign grant_store = grant_data & bus.data_we;

    assign ar_hs = (state_reg == ST_AR) & bus.arready;
    assign aw_hs = (state_reg == ST_AW_W) & ~aw_done_reg & bus.awready;
    assign w_hs  = (state_reg == ST_AW_W) & ~w_done_reg  & bus.wready;

    // A channel counts as complete if it finished earlier or finishes now;
    // this covers both handshakes landing in the same cycle.
    assign aw_ok = aw_done_reg | aw_hs;
    assign w_ok  = w_done_reg  | w_hs;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CCLK) begin
        if (CRST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_any) begin
                    state_next = grant_store ? ST_AW_W : ST_AR;
                end
            end
            ST_AR: begin
                if (ar_hs) begin
                    state_next = ST_R;
                end
            end
            ST_R: begin
                if (bus.rvalid) begin
                    state_next = ST_DONE;
                end
            end
            ST_AW_W: begin
                if (aw_ok && w_ok) begin
                    state_next = ST_B;
                end
            end
            ST_B: begin
                if (bus.bvalid) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Transaction context, channel progress, read data and error flag
    // -----------------------------------------------------------------------
    always_ff @(posedge CCLK) begin
        if (CRST) begin
            owner_data_reg <= 1'b0;
            last_data_reg  <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= 32'h0;
            wdata_reg      <= 32'h0;
            wstrb_reg      <= 4'h0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            rdata_reg      <= 32'h0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Requester inputs are looked at only here; everything
                    // the AXI side needs is frozen until DONE.
                    if (req_any) begin
                        owner_data_reg <= grant_data;
                        last_data_reg  <= grant_data;
                        we_reg         <= grant_store;
                        addr_reg       <= grant_data ? bus.data_addr : bus.inst_addr;
                        wdata_reg      <= bus.data_wdata;
                        wstrb_reg      <= bus.data_wstrb;
                        aw_done_reg    <= 1'b0;
                        w_done_reg     <= 1'b0;
                    end
                end
                ST_R: begin
                    if (bus.rvalid) begin
                        rdata_reg <= bus.rdata;
                        if (bus.rresp != 2'b00) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_AW_W: begin
                    if (aw_hs) begin
                        aw_done_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done_reg <= 1'b1;
                    end
                end
                ST_B: begin
                    if (bus.bvalid && (bus.bresp != 2'b00)) begin
                        err_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode (state and registered flags only)
    // -----------------------------------------------------------------------
    always_comb begin
        bus.arvalid    = 1'b0;
        bus.rready     = 1'b0;
        bus.awvalid    = 1'b0;
        bus.wvalid     = 1'b0;
        bus.bready     = 1'b0;
        bus.inst_ack   = 1'b0;
        bus.data_ack   = 1'b0;
        bus.inst_rdata = 32'h0;
        bus.data_rdata = 32'h0;

        // Address/data come straight from the captured context, so they are
        // stable for as long as the matching VALID is high.
        bus.araddr = addr_reg;
        bus.awaddr = addr_reg;
        bus.wdata  = wdata_reg;
        bus.wstrb  = wstrb_reg;
        bus.wlast  = 1'b1;

        case (state_reg)
            ST_AR: begin
                bus.arvalid = 1'b1;
            end
            ST_R: begin
                bus.rready = 1'b1;
            end
            ST_AW_W: begin
                bus.awvalid = ~aw_done_reg;
                bus.wvalid  = ~w_done_reg;
            end
            ST_B: begin
                bus.bready = 1'b1;
            end
            ST_DONE: begin
                // Only the owner sees the ack and the returned word.
                if (owner_data_reg) begin
                    bus.data_ack = 1'b1;
                    if (!we_reg) begin
                        bus.data_rdata = rdata_reg;
                    end
                end else begin
                    bus.inst_ack   = 1'b1;
                    bus.inst_rdata = rdata_reg;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy = (state_reg != ST_IDLE);
    assign err  = err_reg;

endmodule
